// File: rtl/rv32i_intc_pkg.sv
// Shared definitions for the rv32i interrupt/timer controller.
// The mcause interrupt codes are kept here so the core CSR unit, this
// controller and the benches all agree on a single set of numbers.
package rv32i_intc_pkg;

  // Width of the machine timer and its compare register.
  localparam int MTIME_W = 64;

  // mtimecmp starts at all-ones so no timer interrupt fires until software
  // programs a real deadline.
  localparam logic [MTIME_W-1:0] MTIMECMP_RESET = {MTIME_W{1'b1}};

  // Machine-mode interrupt cause codes (mcause[30:0] with mcause[31]=1).
  localparam logic [3:0] MCAUSE_SOFTWARE_IRQ = 4'd3;
  localparam logic [3:0] MCAUSE_TIMER_IRQ    = 4'd7;
  localparam logic [3:0] MCAUSE_EXTERNAL_IRQ = 4'd11;

  // Gateway trigger mode of one external source.
  typedef enum logic {
    GW_LEVEL = 1'b0,
    GW_EDGE  = 1'b1
  } gw_mode_e;

endpackage

// File: rtl/rv32i_intc_gateway.sv
// Interrupt gateway for one external source.
// The raw line is brought into the clock domain with a two-flop
// synchroniser, then compared against a delayed copy to find rising edges.
// In edge mode a rising edge latches pending until the core claims this
// source; in level mode pending simply follows the synchronised level.
module rv32i_intc_gateway
  import rv32i_intc_pkg::*;
(
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_src,
  input  logic i_edge_mode,
  input  logic i_claim_clr,
  output logic o_pending
);

  logic     sync1;
  logic     sync2;
  logic     sync_d;
  logic     rise;
  gw_mode_e mode;

  assign mode = gw_mode_e'(i_edge_mode);
  assign rise = sync2 & ~sync_d;

  // Synchronise the asynchronous line and keep a one-cycle-old copy for edge detection.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      sync1  <= 1'b0;
      sync2  <= 1'b0;
      sync_d <= 1'b0;
    end else begin
      sync1  <= i_src;
      sync2  <= sync1;
      sync_d <= sync2;
    end
  end

  // Pending flop: an edge arriving together with its claim wins, so it is never lost.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_pending <= 1'b0;
    end else if (mode == GW_EDGE) begin
      if (rise) begin
        o_pending <= 1'b1;
      end else if (i_claim_clr) begin
        o_pending <= 1'b0;
      end
    end else begin
      o_pending <= sync2;
    end
  end

endmodule

// File: rtl/rv32i_intc.sv
// Interrupt and timer controller feeding the rv32i core.
// Three independent pieces live here:
//   - NUM_SRC external sources through per-source gateways, a lowest-index
//     priority encoder and a claim/complete handshake with in-service bits;
//   - a prescaled 64-bit mtime with mtimecmp and a registered compare;
//   - a software interrupt set/clear latch.
// The claim outputs are computed from the next in-service state, so a claim
// or complete is reflected in o_claim_id/o_claim_valid on the very next cycle.
module rv32i_intc
  import rv32i_intc_pkg::*;
#(
  parameter  int NUM_SRC  = 4,
  parameter  int PRESCALE = 100,
  localparam int CLAIM_W  = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1
) (
  input  logic               i_clk,
  input  logic               i_rst_n,
  input  logic [NUM_SRC-1:0] i_src,
  input  logic [NUM_SRC-1:0] i_edge_mode,
  input  logic [NUM_SRC-1:0] i_enable,
  input  logic               i_claim,
  input  logic               i_complete,
  input  logic [CLAIM_W-1:0] i_complete_id,
  output logic [CLAIM_W-1:0] o_claim_id,
  output logic               o_claim_valid,
  output logic               o_external_interrupt,
  input  logic               i_soft_set,
  input  logic               i_soft_clr,
  output logic               o_software_interrupt,
  input  logic               i_mtime_wr,
  input  logic [MTIME_W-1:0] i_mtime_din,
  input  logic               i_mtimecmp_wr,
  input  logic [MTIME_W-1:0] i_mtimecmp_din,
  output logic [MTIME_W-1:0] o_mtime,
  output logic               o_timer_interrupt
);

  localparam int PRE_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(PRESCALE - 1);

  // ---------------------------------------------------------------------
  // External sources
  // ---------------------------------------------------------------------
  logic [NUM_SRC-1:0] pending;
  logic [NUM_SRC-1:0] in_service;
  logic [NUM_SRC-1:0] in_service_next;
  logic [NUM_SRC-1:0] claim_clr;
  logic [NUM_SRC-1:0] complete_hit;
  logic [NUM_SRC-1:0] eligible;
  logic               claim_fire;
  logic               claim_valid_next;
  logic [CLAIM_W-1:0] claim_id_next;

  // A claim only counts when there is actually something to claim.
  assign claim_fire = i_claim & o_claim_valid;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_SRC; gi++) begin : g_gateway
      rv32i_intc_gateway u_gateway (
        .i_clk       (i_clk),
        .i_rst_n     (i_rst_n),
        .i_src       (i_src[gi]),
        .i_edge_mode (i_edge_mode[gi]),
        .i_claim_clr (claim_clr[gi]),
        .o_pending   (pending[gi])
      );
    end
  endgenerate

  // Decode claim and complete IDs; IDs outside 0..NUM_SRC-1 match nothing.
  always_comb begin
    claim_clr    = '0;
    complete_hit = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      claim_clr[i]    = claim_fire && (o_claim_id == CLAIM_W'(i));
      complete_hit[i] = i_complete && (i_complete_id == CLAIM_W'(i));
    end
  end

  // Next in-service set: complete beats a coincident claim of the same ID.
  always_comb begin
    in_service_next = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      in_service_next[i] = (in_service[i] | claim_clr[i]) & ~complete_hit[i];
    end
  end

  assign eligible = pending & i_enable & ~in_service_next;

  // Lowest-index eligible source wins; scanning downwards leaves the lowest hit last.
  always_comb begin
    claim_valid_next = 1'b0;
    claim_id_next    = '0;
    for (int i = NUM_SRC - 1; i >= 0; i--) begin
      if (eligible[i]) begin
        claim_valid_next = 1'b1;
        claim_id_next    = CLAIM_W'(i);
      end
    end
  end

  // Register in-service bits and the claim outputs presented to the core.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      in_service    <= '0;
      o_claim_valid <= 1'b0;
      o_claim_id    <= '0;
    end else begin
      in_service    <= in_service_next;
      o_claim_valid <= claim_valid_next;
      o_claim_id    <= claim_id_next;
    end
  end

  assign o_external_interrupt = o_claim_valid;

  // ---------------------------------------------------------------------
  // Software interrupt
  // ---------------------------------------------------------------------

  // Set has priority so a set racing a clear is never dropped.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_software_interrupt <= 1'b0;
    end else if (i_soft_set) begin
      o_software_interrupt <= 1'b1;
    end else if (i_soft_clr) begin
      o_software_interrupt <= 1'b0;
    end
  end

  // ---------------------------------------------------------------------
  // Machine timer
  // ---------------------------------------------------------------------
  logic [PRE_W-1:0]   prescaler;
  logic [MTIME_W-1:0] mtime;
  logic [MTIME_W-1:0] mtimecmp;
  logic               tick;

  assign tick    = (prescaler == PRE_LAST);
  assign o_mtime = mtime;

  // Prescaler and mtime; a software load restarts the prescale period and beats the tick.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      prescaler <= '0;
      mtime     <= '0;
    end else if (i_mtime_wr) begin
      prescaler <= '0;
      mtime     <= i_mtime_din;
    end else if (tick) begin
      prescaler <= '0;
      mtime     <= mtime + MTIME_W'(1);
    end else begin
      prescaler <= prescaler + PRE_W'(1);
    end
  end

  // Compare register, loaded only by software.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      mtimecmp <= MTIMECMP_RESET;
    end else if (i_mtimecmp_wr) begin
      mtimecmp <= i_mtimecmp_din;
    end
  end

  // Registered compare of the stored values, so the interrupt trails any change by one cycle.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_timer_interrupt <= 1'b0;
    end else begin
      o_timer_interrupt <= (mtime >= mtimecmp);
    end
  end

endmodule

// File: tb/tb_rv32i_intc.sv
// Self-checking bench for rv32i_intc with NUM_SRC=4 and PRESCALE=4.
// Stimulus pushes hand-computed expectations into a queue right after each
// active edge; a monitor pops and compares them on the following falling edge.
module tb_rv32i_intc;
  import rv32i_intc_pkg::*;

  localparam int NUM_SRC  = 4;
  localparam int PRESCALE = 4;
  localparam int CLAIM_W  = 2;

  localparam int SEL_VALID = 0;
  localparam int SEL_ID    = 1;
  localparam int SEL_EXT   = 2;
  localparam int SEL_SOFT  = 3;
  localparam int SEL_MTIME = 4;
  localparam int SEL_TIMER = 5;

  logic               i_clk;
  logic               i_rst_n;
  logic [NUM_SRC-1:0] i_src;
  logic [NUM_SRC-1:0] i_edge_mode;
  logic [NUM_SRC-1:0] i_enable;
  logic               i_claim;
  logic               i_complete;
  logic [CLAIM_W-1:0] i_complete_id;
  logic [CLAIM_W-1:0] o_claim_id;
  logic               o_claim_valid;
  logic               o_external_interrupt;
  logic               i_soft_set;
  logic               i_soft_clr;
  logic               o_software_interrupt;
  logic               i_mtime_wr;
  logic [63:0]        i_mtime_din;
  logic               i_mtimecmp_wr;
  logic [63:0]        i_mtimecmp_din;
  logic [63:0]        o_mtime;
  logic               o_timer_interrupt;

  typedef struct {
    string       name;
    int          sel;
    logic [63:0] exp;
  } exp_t;

  exp_t exp_q[$];
  exp_t cur;
  int   checks   = 0;
  int   failures = 0;

  rv32i_intc #(
    .NUM_SRC  (NUM_SRC),
    .PRESCALE (PRESCALE)
  ) dut (
    .i_clk                (i_clk),
    .i_rst_n              (i_rst_n),
    .i_src                (i_src),
    .i_edge_mode          (i_edge_mode),
    .i_enable             (i_enable),
    .i_claim              (i_claim),
    .i_complete           (i_complete),
    .i_complete_id        (i_complete_id),
    .o_claim_id           (o_claim_id),
    .o_claim_valid        (o_claim_valid),
    .o_external_interrupt (o_external_interrupt),
    .i_soft_set           (i_soft_set),
    .i_soft_clr           (i_soft_clr),
    .o_software_interrupt (o_software_interrupt),
    .i_mtime_wr           (i_mtime_wr),
    .i_mtime_din          (i_mtime_din),
    .i_mtimecmp_wr        (i_mtimecmp_wr),
    .i_mtimecmp_din       (i_mtimecmp_din),
    .o_mtime              (o_mtime),
    .o_timer_interrupt    (o_timer_interrupt)
  );

  // 10 ns clock, rising edges at 5, 15, 25, ...
  initial begin
    i_clk = 1'b0;
    forever #5 i_clk = ~i_clk;
  end

  // Hard stop in case the stimulus ever stalls.
  initial begin
    #100000;
    $display("[TB] FAIL watchdog: got timeout, required completion before 100000 ns");
    $fatal(1, "[TB] watchdog expired");
  end

  function automatic logic [63:0] sampleOutput(input int sel);
    case (sel)
      SEL_VALID: return 64'(o_claim_valid);
      SEL_ID:    return 64'(o_claim_id);
      SEL_EXT:   return 64'(o_external_interrupt);
      SEL_SOFT:  return 64'(o_software_interrupt);
      SEL_MTIME: return o_mtime;
      default:   return 64'(o_timer_interrupt);
    endcase
  endfunction

  // Monitor: consume every queued expectation on the falling edge.
  always @(negedge i_clk) begin
    while (exp_q.size() > 0) begin
      logic [63:0] act;
      cur = exp_q.pop_front();
      act = sampleOutput(cur.sel);
      checks++;
      if (act !== cur.exp) begin
        failures++;
        $display("[TB] FAIL %s: got %0h, required %0h", cur.name, act, cur.exp);
      end
    end
  end

  task automatic checkOutput(input string name, input int sel, input logic [63:0] exp);
    exp_t e;
    e.name = name;
    e.sel  = sel;
    e.exp  = exp;
    exp_q.push_back(e);
  endtask

  // Advance n active edges; single-cycle strobes are dropped after the first edge.
  task automatic applyStimulus(input int n);
    for (int k = 0; k < n; k++) begin
      @(posedge i_clk);
      #1;
      i_claim       = 1'b0;
      i_complete    = 1'b0;
      i_soft_set    = 1'b0;
      i_soft_clr    = 1'b0;
      i_mtime_wr    = 1'b0;
      i_mtimecmp_wr = 1'b0;
    end
  endtask

  task automatic checkClaim(input string name, input logic valid, input logic [CLAIM_W-1:0] id);
    checkOutput({name, "_valid"}, SEL_VALID, 64'(valid));
    if (valid) checkOutput({name, "_id"}, SEL_ID, 64'(id));
  endtask

  initial begin
    i_rst_n        = 1'b0;
    i_src          = '0;
    i_edge_mode    = 4'b0100;
    i_enable       = 4'b1111;
    i_claim        = 1'b0;
    i_complete     = 1'b0;
    i_complete_id  = '0;
    i_soft_set     = 1'b0;
    i_soft_clr     = 1'b0;
    i_mtime_wr     = 1'b0;
    i_mtime_din    = '0;
    i_mtimecmp_wr  = 1'b0;
    i_mtimecmp_din = '0;

    // Reset state
    #2;
    checkOutput("rst_valid", SEL_VALID, 64'd0);
    checkOutput("rst_id", SEL_ID, 64'd0);
    checkOutput("rst_ext", SEL_EXT, 64'd0);
    checkOutput("rst_soft", SEL_SOFT, 64'd0);
    checkOutput("rst_mtime", SEL_MTIME, 64'd0);
    checkOutput("rst_timer", SEL_TIMER, 64'd0);
    applyStimulus(2);
    i_rst_n = 1'b1;

    // Timer: mtimecmp=15, mtime reaches 15 at edge 60, interrupt at edge 61
    i_mtimecmp_wr  = 1'b1;
    i_mtimecmp_din = 64'd15;
    applyStimulus(1);
    for (int k = 2; k <= 61; k++) begin
      applyStimulus(1);
      if (k == 59) begin
        checkOutput("tmr_mtime59", SEL_MTIME, 64'd14);
        checkOutput("tmr_irq59", SEL_TIMER, 64'd0);
      end
      if (k == 60) begin
        checkOutput("tmr_mtime60", SEL_MTIME, 64'd15);
        checkOutput("tmr_irq60", SEL_TIMER, 64'd0);
      end
      if (k == 61) checkOutput("tmr_irq61", SEL_TIMER, 64'd1);
    end

    // Load mtime=0: interrupt stays one more cycle, then drops
    i_mtime_wr  = 1'b1;
    i_mtime_din = 64'd0;
    applyStimulus(1);
    checkOutput("ld0_mtime", SEL_MTIME, 64'd0);
    checkOutput("ld0_irq_lag", SEL_TIMER, 64'd1);
    applyStimulus(1);
    checkOutput("ld0_irq_drop", SEL_TIMER, 64'd0);

    // Wrap from all-ones to zero after one prescale period
    i_mtime_wr  = 1'b1;
    i_mtime_din = 64'hFFFF_FFFF_FFFF_FFFF;
    applyStimulus(1);
    checkOutput("wrap_load", SEL_MTIME, 64'hFFFF_FFFF_FFFF_FFFF);
    applyStimulus(3);
    checkOutput("wrap_hold", SEL_MTIME, 64'hFFFF_FFFF_FFFF_FFFF);
    checkOutput("wrap_irq_hi", SEL_TIMER, 64'd1);
    applyStimulus(1);
    checkOutput("wrap_zero", SEL_MTIME, 64'd0);
    applyStimulus(1);
    checkOutput("wrap_irq_lo", SEL_TIMER, 64'd0);

    // Software interrupt: set beats clear
    i_soft_set = 1'b1;
    i_soft_clr = 1'b1;
    applyStimulus(1);
    checkOutput("soft_both", SEL_SOFT, 64'd1);
    i_soft_clr = 1'b1;
    applyStimulus(1);
    checkOutput("soft_clr", SEL_SOFT, 64'd0);

    // Edge source 2: pulse, interrupt 3 edges after the first sampling edge
    i_src[2] = 1'b1;
    applyStimulus(1);
    checkOutput("edge_n", SEL_EXT, 64'd0);
    applyStimulus(1);
    i_src[2] = 1'b0;
    checkOutput("edge_n1", SEL_EXT, 64'd0);
    applyStimulus(1);
    checkOutput("edge_n2", SEL_EXT, 64'd0);
    applyStimulus(1);
    checkOutput("edge_n3", SEL_EXT, 64'd1);
    checkClaim("edge_n3", 1'b1, 2'd2);
    applyStimulus(3);
    checkOutput("edge_held", SEL_EXT, 64'd1);
    i_claim = 1'b1;
    applyStimulus(1);
    checkClaim("edge_claimed", 1'b0, 2'd0);
    i_complete    = 1'b1;
    i_complete_id = 2'd2;
    applyStimulus(1);
    checkClaim("edge_done", 1'b0, 2'd0);

    // Priority and handshake with level sources 1 and 3
    i_src = 4'b1010;
    applyStimulus(3);
    checkOutput("prio_early", SEL_EXT, 64'd0);
    applyStimulus(1);
    checkClaim("prio_first", 1'b1, 2'd1);
    i_claim = 1'b1;
    applyStimulus(1);
    checkClaim("prio_second", 1'b1, 2'd3);
    i_claim = 1'b1;
    applyStimulus(1);
    checkClaim("prio_none", 1'b0, 2'd0);
    i_complete    = 1'b1;
    i_complete_id = 2'd1;
    applyStimulus(1);
    checkClaim("prio_recomp", 1'b1, 2'd1);
    i_claim = 1'b1;
    applyStimulus(1);
    checkClaim("prio_reclaim", 1'b0, 2'd0);
    i_src = 4'b0000;
    applyStimulus(4);
    i_complete    = 1'b1;
    i_complete_id = 2'd3;
    applyStimulus(1);
    i_complete    = 1'b1;
    i_complete_id = 2'd1;
    applyStimulus(1);
    checkClaim("prio_idle", 1'b0, 2'd0);

    // Same-cycle claim and complete of level source 2
    i_edge_mode = 4'b0000;
    i_src[2]    = 1'b1;
    applyStimulus(4);
    checkClaim("same_pend", 1'b1, 2'd2);
    i_claim       = 1'b1;
    i_complete    = 1'b1;
    i_complete_id = 2'd2;
    applyStimulus(1);
    checkClaim("same_cc", 1'b1, 2'd2);
    i_claim = 1'b1;
    applyStimulus(1);
    checkClaim("same_claim", 1'b0, 2'd0);
    i_src[2] = 1'b0;
    applyStimulus(4);
    i_complete    = 1'b1;
    i_complete_id = 2'd2;
    applyStimulus(1);
    checkClaim("same_idle", 1'b0, 2'd0);

    // Claim with nothing valid is ignored; disabled source waits for enable
    i_claim = 1'b1;
    applyStimulus(1);
    i_enable[0] = 1'b0;
    i_src[0]    = 1'b1;
    applyStimulus(5);
    checkClaim("en_masked", 1'b0, 2'd0);
    i_enable[0] = 1'b1;
    applyStimulus(1);
    checkClaim("en_restored", 1'b1, 2'd0);
    i_claim = 1'b1;
    applyStimulus(1);
    checkClaim("en_claimed", 1'b0, 2'd0);

    // Reset mid-operation: src0 in service, mtime=37, soft set, timer high
    i_mtime_wr  = 1'b1;
    i_mtime_din = 64'd37;
    i_soft_set  = 1'b1;
    applyStimulus(1);
    checkOutput("pre_mtime", SEL_MTIME, 64'd37);
    checkOutput("pre_soft", SEL_SOFT, 64'd1);
    applyStimulus(1);
    checkOutput("pre_timer", SEL_TIMER, 64'd1);
    @(negedge i_clk);
    #1;
    i_rst_n = 1'b0;
    checkOutput("arst_valid", SEL_VALID, 64'd0);
    checkOutput("arst_id", SEL_ID, 64'd0);
    checkOutput("arst_ext", SEL_EXT, 64'd0);
    checkOutput("arst_soft", SEL_SOFT, 64'd0);
    checkOutput("arst_mtime", SEL_MTIME, 64'd0);
    checkOutput("arst_timer", SEL_TIMER, 64'd0);
    applyStimulus(1);
    i_rst_n = 1'b1;
    applyStimulus(2);
    checkOutput("rel_ext_early", SEL_EXT, 64'd0);
    checkOutput("rel_mtime_early", SEL_MTIME, 64'd0);
    applyStimulus(2);
    checkOutput("rel_ext", SEL_EXT, 64'd1);
    checkClaim("rel", 1'b1, 2'd0);
    checkOutput("rel_mtime", SEL_MTIME, 64'd1);
    checkOutput("rel_timer", SEL_TIMER, 64'd0);

    applyStimulus(2);
    if (exp_q.size() != 0) begin
      failures += exp_q.size();
      $display("[TB] FAIL drain: got %0d unchecked, required 0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
